// File: rtl/fp_pkg.sv
// Shared types and constants for the sign-less 31-bit float datapath.
// Latency: n/a (types, constants and a combinational classify helper).
// Backpressure: n/a.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;       // mantissa with hidden one
  localparam int BIAS   = 127;

  // Quotient bits from the restoring divider: 24 mantissa bits + 1 guard bit.
  localparam int QBITS   = MANT_W + 1;
  // Start-to-valid latency: one NORM cycle, QBITS DIV cycles, one RND cycle.
  localparam int LATENCY = QBITS + 2;

  localparam logic [EXP_W+FRAC_W-1:0] FP_INF  = 31'h7F800000;
  localparam logic [EXP_W+FRAC_W-1:0] FP_QNAN = 31'h7FC00000;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp31_t;

  typedef enum logic [1:0] {
    FC_ZERO,
    FC_NORMAL,
    FC_INF,
    FC_NAN
  } fp_class_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_DIV,
    S_RND
  } div_state_e;

  // Exponent 0 is always zero: subnormals are flushed, not supported.
  function automatic fp_class_e fp_class(input fp31_t x);
    fp_class_e c;
    if (x.exp == '0) begin
      c = FC_ZERO;
    end else if (x.exp == '1) begin
      if (x.frac == '0) c = FC_INF;
      else              c = FC_NAN;
    end else begin
      c = FC_NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_div_core.sv
// Restoring mantissa divider: remainder, quotient shift register, bit counter.
// Latency: one quotient bit per step; last is high on the step that produces bit 0.
// Backpressure: none; ce freezes every register, load/step are driven by the owning FSM.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   ce            clock enable, freezes all state when low
//   load          initialise remainder with dividend, latch divisor, arm counter
//   step          perform one restoring iteration
//   dividend      normalised dividend (MW+1 bits, value in [divisor, 2*divisor))
//   divisor       divisor mantissa with hidden one (MW bits)
//   quo           quotient shift register, MSB first
//   rem_nz        remainder is non-zero (sticky source)
//   last          counter has reached zero (current step is the final one)
module fp_div_core
  import fp_pkg::*;
#(
  parameter int QBITS = 25,
  parameter int MW    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             load,
  input  logic             step,
  input  logic [MW:0]      dividend,
  input  logic [MW-1:0]    divisor,
  output logic [QBITS-1:0] quo,
  output logic             rem_nz,
  output logic             last
);

  localparam int CNT_W = $clog2(QBITS);

  logic [MW:0]      rem_q,  rem_d;
  logic [MW-1:0]    mb_q,   mb_d;
  logic [QBITS-1:0] quo_q,  quo_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic             ge;
  logic [MW:0]      diff;

  always_comb begin
    rem_d = rem_q;
    mb_d  = mb_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    ge    = 1'b0;
    diff  = rem_q;

    if (load) begin
      // The remainder starts from the (already normalised) dividend, so the
      // first step always yields the integer quotient bit.
      rem_d = dividend;
      mb_d  = divisor;
      quo_d = '0;
      cnt_d = CNT_W'(QBITS - 1);
    end else if (step) begin
      ge    = (rem_q >= {1'b0, mb_q});
      diff  = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
      // diff < divisor here, so the shift cannot overflow MW+1 bits.
      rem_d = diff << 1;
      quo_d = {quo_q[QBITS-2:0], ge};
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      mb_q  <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (ce) begin
      rem_q <= rem_d;
      mb_q  <= mb_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  assign quo    = quo_q;
  assign rem_nz = (rem_q != '0);
  assign last   = (cnt_q == '0);

endmodule

// File: rtl/fp_div_seq.sv
// Iterative sign-less single-precision divider q = a / b, round to nearest even.
// Latency: fixed QBITS+2 (27) ce-qualified cycles from accepted start to valid, for every input.
// Backpressure: start is ignored while busy; ce low freezes the whole block, including a valid pulse.
//
// Ports:
//   clk, rst   rising-edge clock, async active-high reset (aborts any operation)
//   ce         clock enable
//   start      request; accepted only when busy=0 and ce=1
//   a, b       dividend / divisor, {exp[7:0], frac[22:0]}
//   q          quotient, updated only in the rounding cycle, held otherwise
//   valid      one-cycle pulse marking q
//   busy       high from the cycle after acceptance through the valid cycle
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        start,
  input  logic [30:0] a,
  input  logic [30:0] b,
  output logic [30:0] q,
  output logic        valid,
  output logic        busy
);

  div_state_e         state_q, state_d;
  fp31_t              a_q, a_d;
  fp31_t              b_q, b_d;
  logic               spec_q, spec_d;
  logic [30:0]        spec_val_q, spec_val_d;
  logic signed [9:0]  e_q, e_d;
  logic [30:0]        q_q, q_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  // Datapath handshake with the divider core.
  logic               core_load, core_step;
  logic [MANT_W:0]    dividend;
  logic [MANT_W-1:0]  divisor;
  logic [QBITS-1:0]   quo;
  logic               rem_nz, core_last;

  // Combinational helpers.
  fp_class_e          ca, cb;
  logic [MANT_W-1:0]  mant_a, mant_b;
  logic signed [9:0]  e_tmp;
  logic [MANT_W-1:0]  mant;
  logic               guard, sticky, round_up;
  logic [MANT_W:0]    mant_sum;
  logic [MANT_W-1:0]  mant_r;
  logic signed [9:0]  e_r;

  assign ca = fp_class(fp31_t'(a));
  assign cb = fp_class(fp31_t'(b));

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    e_d        = e_q;
    q_d        = q_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;

    core_load  = 1'b0;
    core_step  = 1'b0;
    mant_a     = {1'b1, a_q.frac};
    mant_b     = {1'b1, b_q.frac};
    dividend   = {1'b0, mant_a};
    divisor    = mant_b;
    e_tmp      = $signed({2'b00, a_q.exp}) - $signed({2'b00, b_q.exp}) + 10'sd127;

    mant       = quo[QBITS-1:1];
    guard      = quo[0];
    sticky     = rem_nz;
    round_up   = 1'b0;
    mant_sum   = '0;
    mant_r     = '0;
    e_r        = e_q;

    unique case (state_q)
      S_IDLE: begin
        if (busy_q) begin
          // Cycle holding the valid pulse: busy ends here and start is ignored.
          busy_d = 1'b0;
        end else if (start) begin
          a_d     = a;
          b_d     = b;
          busy_d  = 1'b1;
          state_d = S_NORM;
          // Specials are resolved now but still run the full pipeline so the
          // latency never depends on the operands.
          spec_d     = 1'b1;
          spec_val_d = '0;
          if (ca == FC_NAN || cb == FC_NAN ||
              (ca == FC_ZERO && cb == FC_ZERO) ||
              (ca == FC_INF && cb == FC_INF)) begin
            spec_val_d = FP_QNAN;
          end else if (cb == FC_ZERO || ca == FC_INF) begin
            spec_val_d = FP_INF;
          end else if (ca == FC_ZERO || cb == FC_INF) begin
            spec_val_d = '0;
          end else begin
            spec_d = 1'b0;
          end
        end
      end

      S_NORM: begin
        // Pre-shift the dividend so the quotient lands in [1,2).
        if (mant_a < mant_b) begin
          dividend = {mant_a, 1'b0};
          e_d      = e_tmp - 10'sd1;
        end else begin
          dividend = {1'b0, mant_a};
          e_d      = e_tmp;
        end
        core_load = 1'b1;
        state_d   = S_DIV;
      end

      S_DIV: begin
        core_step = 1'b1;
        if (core_last) state_d = S_RND;
      end

      S_RND: begin
        round_up = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
        if (mant_sum[MANT_W]) begin
          mant_r = {1'b1, {FRAC_W{1'b0}}};
          e_r    = e_q + 10'sd1;
        end else begin
          mant_r = mant_sum[MANT_W-1:0];
          e_r    = e_q;
        end

        if (spec_q)                q_d = spec_val_q;
        else if (e_r >= 10'sd255)  q_d = FP_INF;
        else if (e_r <= 10'sd0)    q_d = '0;
        else                       q_d = {e_r[EXP_W-1:0], FRAC_W'(mant_r)};

        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      e_q        <= '0;
      q_q        <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else if (ce) begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      e_q        <= e_d;
      q_q        <= q_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  fp_div_core #(
    .QBITS (QBITS),
    .MW    (MANT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .load     (core_load),
    .step     (core_step),
    .dividend (dividend),
    .divisor  (divisor),
    .quo      (quo),
    .rem_nz   (rem_nz),
    .last     (core_last)
  );

  assign q     = q_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq.
// Latency: expects valid exactly 27 ce=1 edges after the accepting edge.
// Backpressure: exercises ignored starts, ce stalls, held valid and mid-op reset.
module tb_fp_div_seq;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        start;
  logic [30:0] a;
  logic [30:0] b;
  logic [30:0] q;
  logic        valid;
  logic        busy;

  int n_vec;
  int n_err;

  fp_div_seq dut (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .valid (valid),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation from a negedge and follow it to completion.
  //   stall_at/stall_len : drop ce for stall_len edges starting at that cycle
  //   restart_at         : pulse a competing start (1.0/1.0) at that cycle
  //   reset_at           : assert rst at that cycle and expect the op to vanish
  //   hold               : freeze ce for 3 edges while valid is high
  task automatic run_op(input string tag, input logic [30:0] ta, input logic [30:0] tb_v,
                        input logic [30:0] exp_q, input int stall_at, input int stall_len,
                        input int restart_at, input int reset_at, input bit hold);
    int  edges;
    bit  busy_ok;
    bit  got_valid;
    bit  saw_valid;
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    edges     = 0;
    busy_ok   = 1'b1;
    got_valid = 1'b0;
    while (!got_valid && edges < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (valid) begin
        got_valid = 1'b1;
      end else if (edges == reset_at) begin
        rst = 1'b1;
        #1;
        check({tag, "_rst_q"},     {1'b0, q}, 32'h0);
        check({tag, "_rst_valid"}, {31'h0, valid}, 32'h0);
        check({tag, "_rst_busy"},  {31'h0, busy}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (valid) saw_valid = 1'b1;
        end
        check({tag, "_rst_novalid"}, {31'h0, saw_valid}, 32'h0);
        return;
      end else begin
        ce = !(edges >= stall_at && edges < stall_at + stall_len);
        if (edges == restart_at) begin
          a     = 31'h3F800000;
          b     = 31'h3F800000;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    ce    = 1'b1;
    check({tag, "_got_valid"}, {31'h0, got_valid}, 32'h1);
    check({tag, "_latency"},   edges, 27 + stall_len);
    check({tag, "_q"},         {1'b0, q}, {1'b0, exp_q});
    check({tag, "_busy_run"},  {31'h0, busy_ok}, 32'h1);
    if (hold) begin
      ce = 1'b0;
      repeat (3) @(negedge clk);
      check({tag, "_hold_valid"}, {31'h0, valid}, 32'h1);
      check({tag, "_hold_q"},     {1'b0, q}, {1'b0, exp_q});
      ce = 1'b1;
    end
    @(negedge clk);
    check({tag, "_valid_pulse"}, {31'h0, valid}, 32'h0);
    check({tag, "_busy_end"},    {31'h0, busy}, 32'h0);
    check({tag, "_q_hold"},      {1'b0, q}, {1'b0, exp_q});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    ce    = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset_q",     {1'b0, q}, 32'h0);
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_busy",  {31'h0, busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Main function
    run_op("six_by_two",  31'h40C00000, 31'h40000000, 31'h40400000, -1, 0, -1, -1, 1'b0);
    run_op("one_by_three",31'h3F800000, 31'h40400000, 31'h3EAAAAAB, -1, 0, -1, -1, 1'b0);
    run_op("one_by_one",  31'h3F800000, 31'h3F800000, 31'h3F800000, -1, 0, -1, -1, 1'b0);

    // Special operands
    run_op("x_by_zero",   31'h3F800000, 31'h00000000, 31'h7F800000, -1, 0, -1, -1, 1'b0);
    run_op("zero_by_x",   31'h00000000, 31'h40A00000, 31'h00000000, -1, 0, -1, -1, 1'b0);
    run_op("zero_by_zero",31'h00000000, 31'h00000000, 31'h7FC00000, -1, 0, -1, -1, 1'b0);
    run_op("inf_by_two",  31'h7F800000, 31'h40000000, 31'h7F800000, -1, 0, -1, -1, 1'b0);
    run_op("inf_by_inf",  31'h7F800000, 31'h7F800000, 31'h7FC00000, -1, 0, -1, -1, 1'b0);
    run_op("nan_by_one",  31'h7F800001, 31'h3F800000, 31'h7FC00000, -1, 0, -1, -1, 1'b0);
    run_op("two_by_inf",  31'h40000000, 31'h7F800000, 31'h00000000, -1, 0, -1, -1, 1'b0);
    run_op("subn_by_one", 31'h00400000, 31'h3F800000, 31'h00000000, -1, 0, -1, -1, 1'b0);

    // Range limits
    run_op("overflow",    31'h7F7FFFFF, 31'h3A83126F, 31'h7F800000, -1, 0, -1, -1, 1'b0);
    run_op("underflow",   31'h00800000, 31'h7F000000, 31'h00000000, -1, 0, -1, -1, 1'b0);

    // Handshake and stall
    run_op("restart_ign", 31'h40C00000, 31'h40000000, 31'h40400000, -1, 0,  5, -1, 1'b0);
    run_op("ce_stall",    31'h3F800000, 31'h40400000, 31'h3EAAAAAB, 10, 10, -1, -1, 1'b0);
    run_op("valid_hold",  31'h3F800000, 31'h3F800000, 31'h3F800000, -1, 0, -1, -1, 1'b1);

    // Reset mid-operation, then a clean operation afterwards
    run_op("mid_reset",   31'h3F800000, 31'h40400000, 31'h3EAAAAAB, -1, 0, -1, 12, 1'b0);
    run_op("after_reset", 31'h40C00000, 31'h40000000, 31'h40400000, -1, 0, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
